// File: rtl/lsu_mem_ctrl.sv
// +--------------------------------------------------------------------------+
// | lsu_mem_ctrl : MEM-stage load/store controller (align, handshake, extend) |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [3:0]        mask,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam logic [3:0] c_mask_lb  = 4'b0000;
  localparam logic [3:0] c_mask_lh  = 4'b0001;
  localparam logic [3:0] c_mask_lbu = 4'b0010;
  localparam logic [3:0] c_mask_lhu = 4'b0100;
  localparam logic [3:0] c_mask_lw  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [3:0]          mask_q, mask_d;
  logic [1:0]          off_q, off_d;

  logic                w_is_byte;
  logic                w_is_half;
  logic                w_is_word;
  logic                w_is_unsigned;
  logic                w_illegal;
  logic [3:0]          w_be;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_shifted;
  logic [DATA_W-1:0]   w_load;

  assign w_is_byte     = (mask == c_mask_lb) || (mask == c_mask_lbu);
  assign w_is_half     = (mask == c_mask_lh) || (mask == c_mask_lhu);
  assign w_is_word     = (mask == c_mask_lw);
  assign w_is_unsigned = (mask == c_mask_lbu) || (mask == c_mask_lhu);

  assign w_illegal = !(w_is_byte || w_is_half || w_is_word)
                   || (req_we && w_is_unsigned)
                   || (w_is_half && req_addr[0])
                   || (w_is_word && (req_addr[1:0] != 2'b00));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    if (w_is_byte) begin
      w_be    = 4'b0001 << req_addr[1:0];
      w_wdata = {4{req_wdata[7:0]}};
    end else if (w_is_half) begin
      w_be    = 4'b0011 << req_addr[1:0];
      w_wdata = {2{req_wdata[15:0]}};
    end
  end

  // Extraction uses the offset/mask latched at accept, not the live inputs.
  assign w_shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (mask_q)
      c_mask_lb:  w_load = {{(DATA_W-8){w_shifted[7]}}, w_shifted[7:0]};
      c_mask_lbu: w_load = {{(DATA_W-8){1'b0}}, w_shifted[7:0]};
      c_mask_lh:  w_load = {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
      c_mask_lhu: w_load = {{(DATA_W-16){1'b0}}, w_shifted[15:0]};
      default:    w_load = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    mask_d       = mask_q;
    off_d        = off_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mask_d = mask;
          off_d  = req_addr[1:0];
          if (w_illegal) begin
            state_d      = ERR;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            rdata_d      = '0;
          end else begin
            state_d     = BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = w_be;
            mem_wdata_d = w_wdata;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = '0;
          mem_be_d     = '0;
          mem_wdata_d  = '0;
          resp_valid_d = 1'b1;
          err_d        = 1'b0;
          rdata_d      = mem_we_q ? '0 : w_load;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        err_d        = 1'b0;
        rdata_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      mask_q       <= '0;
      off_q        <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      mask_q       <= mask_d;
      off_q        <= off_d;
    end
  end

  assign stall      = !rst && (((state_q == IDLE) && req_valid) || (state_q == BUSY));
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_lsu_mem_ctrl : scoreboard bench with byte-level reference memory       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  mask;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;

  lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .mask       (mask),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  mem_t  mq[$];
  resp_t rq[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_delay = 0;
  bit no_stray  = 1'b0;

  // Reference memory is byte-addressed; the memory responder keeps words.
  logic [7:0]  ref_bytes [logic [31:0]];
  logic [31:0] dut_words [logic [31:0]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h1234ABCD;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_bytes.exists(a)) return ref_bytes[a];
    w = init_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] dut_word(input logic [31:0] wa);
    if (dut_words.exists(wa)) return dut_words[wa];
    return init_word(wa);
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] w);
    dut_words[wa] = w;
    for (int k = 0; k < 4; k++) ref_bytes[wa + k] = w[8*k +: 8];
  endtask

  // Memory responder: acks after ack_delay waiting cycles; stray acks when idle.
  initial begin
    int          wcnt;
    logic [31:0] w;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wcnt      = 0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        if (wcnt >= ack_delay) begin
          w         = dut_word(mem_addr);
          mem_ack   = 1'b1;
          mem_rdata = w;
          if (mem_we) begin
            for (int i = 0; i < 4; i++)
              if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            dut_words[mem_addr] = w;
          end
          wcnt = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          wcnt++;
        end
      end else begin
        wcnt      = 0;
        mem_ack   = no_stray ? 1'b0 : 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: compares memory-side requests and responses against the queues.
  initial begin
    mem_t  me;
    resp_t re;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && mem_req) begin
        if (mq.size() == 0) fail_now("mem_req_unexpected");
        else begin
          me = mq[0];
          check("mem_addr", mem_addr, me.addr);
          check("mem_we", 32'(mem_we), 32'(me.we));
          check("mem_be", 32'(mem_be), 32'(me.be));
          if (me.we) check("mem_wdata", mem_wdata, me.wdata);
          if (mem_ack) void'(mq.pop_front());
        end
      end
      if (!rst && resp_valid) begin
        if (rq.size() == 0) fail_now("resp_unexpected");
        else begin
          re = rq.pop_front();
          check("rdata", rdata, re.rdata);
          check("err", 32'(err), 32'(re.err));
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [3:0] m, input logic [31:0] a,
                       input logic [31:0] wd, input int dly);
    int          sz;
    int          n;
    bit          sgn;
    bit          known;
    bit          ok;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [63:0] val;
    mem_t        me;
    resp_t       re;
    known = 1'b1;
    sgn   = 1'b0;
    sz    = 1;
    case (m)
      4'b0000: begin sz = 1; sgn = 1'b1; end
      4'b0010: begin sz = 1; sgn = 1'b0; end
      4'b0001: begin sz = 2; sgn = 1'b1; end
      4'b0100: begin sz = 2; sgn = 1'b0; end
      4'b1000: begin sz = 4; sgn = 1'b0; end
      default: known = 1'b0;
    endcase
    ok = known && !(we && !sgn && sz < 4) && ((int'(a[1:0]) % sz) == 0);

    @(negedge clk);
    ack_delay = dly;
    req_valid = 1'b1;
    req_we    = we;
    mask      = m;
    req_addr  = a;
    req_wdata = wd;

    if (ok) begin
      be  = '0;
      ewd = '0;
      for (int k = 0; k < sz; k++) be[int'(a[1:0]) + k] = 1'b1;
      for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % sz) +: 8];
      me.addr  = {a[31:2], 2'b00};
      me.we    = we;
      me.be    = be;
      me.wdata = ewd;
      mq.push_back(me);
      val = '0;
      if (we) begin
        for (int k = 0; k < sz; k++) ref_bytes[a + k] = wd[8*k +: 8];
      end else begin
        for (int k = 0; k < sz; k++) val = val | (64'(ref_byte(a + k)) << (8*k));
        if (sgn && val[8*sz-1]) val = val | ~((64'd1 << (8*sz)) - 64'd1);
      end
      re.rdata = we ? 32'h0 : val[31:0];
      re.err   = 1'b0;
    end else begin
      re.rdata = 32'h0;
      re.err   = 1'b1;
    end
    rq.push_back(re);

    n = 0;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (!stall) break;
      n++;
      @(negedge clk);
    end
    if (n >= 40) fail_now("stall_timeout");
    else check("stall_cycles", 32'(n), ok ? 32'(2 + dly) : 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    mem_t me;
    resp_t re;
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    mask      = 4'b1000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    req_valid = 1'b0;
    rst       = 1'b0;

    // Directed loads
    preload(32'h1000, 32'h80AA_BBCC);
    issue(1'b0, 4'b0000, 32'h1003, 32'h0, 1);
    preload(32'h1000, 32'h1234_F678);
    issue(1'b0, 4'b0010, 32'h1002, 32'h0, 0);
    issue(1'b0, 4'b0100, 32'h1002, 32'h0, 2);
    issue(1'b0, 4'b0001, 32'h1000, 32'h0, 1);

    // Directed stores, then read back the whole word
    issue(1'b1, 4'b0000, 32'h2001, 32'hDEAD_BEEF, 0);
    issue(1'b1, 4'b0001, 32'h2002, 32'hDEAD_BEEF, 1);
    issue(1'b1, 4'b1000, 32'h2004, 32'hCAFE_F00D, 0);
    issue(1'b0, 4'b1000, 32'h2000, 32'h0, 0);
    issue(1'b0, 4'b1000, 32'h2004, 32'h0, 0);

    // Illegal accesses
    issue(1'b0, 4'b1000, 32'h3002, 32'h0, 0);
    issue(1'b1, 4'b0001, 32'h3001, 32'h1111_2222, 0);
    issue(1'b1, 4'b0100, 32'h3000, 32'h1111_2222, 0);
    issue(1'b0, 4'b0011, 32'h3000, 32'h0, 0);

    // Reset while waiting for an ack that never comes
    no_stray = 1'b1;
    @(negedge clk);
    ack_delay = 1000;
    req_valid = 1'b1;
    req_we    = 1'b0;
    mask      = 4'b1000;
    req_addr  = 32'h40;
    me.addr = 32'h40; me.we = 1'b0; me.be = 4'b1111; me.wdata = '0;
    mq.push_back(me);
    re.rdata = '0; re.err = 1'b0;
    rq.push_back(re);
    repeat (3) @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid_mem_req", 32'(mem_req), 32'd0);
    check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    check("rstmid_stall", 32'(stall), 32'd0);
    mq.delete();
    rq.delete();
    rst      = 1'b0;
    no_stray = 1'b0;
    issue(1'b0, 4'b1000, 32'h0, 32'h0, 0);

    // Back-to-back with immediate ack
    issue(1'b0, 4'b1000, 32'h10, 32'h0, 0);
    issue(1'b1, 4'b1000, 32'h10, 32'hA5A5_0F0F, 0);
    issue(1'b0, 4'b1000, 32'h10, 32'h0, 0);

    // Randomized traffic over a small window so stores and loads overlap
    for (int i = 0; i < 150; i++) begin
      logic [3:0] m;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0: m = 4'b0000;
        1: m = 4'b0001;
        2: m = 4'b1000;
        3: m = 4'b0010;
        4: m = 4'b0100;
        5: m = 4'b1000;
        6: m = 4'b0000;
        default: m = 4'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        req_valid = 1'b0;
      end
      issue(1'($urandom_range(0, 1)), m, 32'h100 + 32'($urandom_range(0, 15)),
            $urandom, $urandom_range(0, 2));
    end

    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mem_queue_drained", 32'(mq.size()), 32'd0);
    check("resp_queue_drained", 32'(rq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
